ucsbece154a_memcpy: RTL
=======================

Name: ucsbece154a_memcpy

Overview:
- Bus initiator (DMA-style word copier) driving the single shared port of ucsbece154a_mem: a_i, we_i, wd_i, rd_o.
- Copies LEN words from a source range (text or data region) to a destination range (data region only).
- Uses burst buffering: reads up to BURST words, then writes them out, then repeats.
- A top-level mux hands the memory port to this block while mem_req_o is high. Arbitration against the processor is outside this block.

Parameters:
- TEXT_SIZE, 64, text region size in words; must match the memory instance.
- DATA_SIZE, 64, data region size in words; must match the memory instance.
- BURST, 4, burst buffer depth in words; power of two, ≥1.
- Fixed localparams: TEXT_START=32'h00400000, DATA_START=32'h10000000, TEXT_END=TEXT_START+4*TEXT_SIZE, DATA_END=DATA_START+4*DATA_SIZE.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset_n  input  1  asynchronous active-low reset.
- start_i  input  1  start request; sampled only in IDLE.
- src_i  input  32  source byte address.
- dst_i  input  32  destination byte address.
- len_i  input  16  word count.
- busy_o  output  1  high during READ/WRITE states.
- done_o  output  1  one-cycle pulse on successful completion.
- err_o  output  1  one-cycle pulse on a rejected request.
- mem_req_o  output  1  equals busy_o; grant select for the top-level mux.
- mem_a_o  output  32  memory address.
- mem_we_o  output  1  memory write enable.
- mem_wd_o  output  32  memory write data.
- mem_rd_i  input  32  memory read data; combinational from mem_a_o.

Behaviour:
- Reset (asynchronous, immediate):
  - State goes to IDLE.
  - All outputs go to 0, including mem_a_o=0 and mem_we_o=0.
  - Counters and buffer pointer clear; buffer contents are don't-care.
- States: IDLE, CHECK, READ, WRITE, FIN.
- IDLE:
  - On posedge with start_i=1, latch src, dst and len, then go to CHECK.
  - Otherwise stay in IDLE.
- CHECK (one cycle, no memory access, mem_we_o=0). A request is valid only when all of these hold:
  - src[1:0]==0 and dst[1:0]==0.
  - [src, src+4*len) lies entirely within [TEXT_START,TEXT_END) or entirely within [DATA_START,DATA_END).
  - [dst, dst+4*len) lies within [DATA_START,DATA_END).
  - If src is in the data region, the two ranges do not intersect.
  - All sums use 34-bit arithmetic, so no wrap-around is possible.
- CHECK outcomes:
  - len==0 → FIN (done with no accesses).
  - Invalid request → err_o=1 for exactly that cycle, then IDLE.
  - Otherwise → READ with burst count n=min(BURST, remaining).
- READ (busy_o=1):
  - mem_a_o = current src pointer, mem_we_o=0.
  - At posedge, buf[idx] <= mem_rd_i, src += 4, idx++.
  - After n reads, go to WRITE with idx=0.
- WRITE (busy_o=1):
  - mem_a_o = current dst pointer, mem_we_o=1, mem_wd_o=buf[idx].
  - At posedge, dst += 4, idx++, remaining--.
  - After n writes: remaining==0 → FIN, otherwise → READ with a new n.
- FIN: done_o=1 for one cycle, busy_o=0, then IDLE.
- Latency: a valid copy of N≥1 words occupies exactly 2N busy cycles. done_o asserts in the cycle after the last write, i.e. start posedge + 2N + 2 cycles.
- Outside READ/WRITE, mem_a_o=0, mem_we_o=0 and mem_wd_o=0.
- start_i is ignored outside IDLE. start_i held high across FIN begins a new copy at the next IDLE posedge.
- Reset mid-copy: words already written remain in memory, and no further writes occur. mem_we_o drops asynchronously.
- err_o and done_o are never high in the same cycle.

Test Plan:
- Preload DATA[0..5]=1..6; src=0x10000000, dst=0x10000040, len=6. Required: writes at 0x10000040..54 with values 1..6; burst order RRRR WWWW RR WW; busy_o high 12 cycles; done_o pulses exactly once.
- src=0x00400000 (text), dst=0x10000000, len=3. Required: DATA[0..2] equals TEXT[0..2].
- len=0 with valid addresses. Required: done_o pulses 2 cycles after start; mem_we_o never asserts.
- Each error case must pulse err_o once with zero writes:
  - dst=0x10000002 (misaligned).
  - dst=0x100000F8, len=4 (exceeds DATA_END=0x10000100).
  - src=0x10000000, dst=0x10000008, len=4 (overlap).
- Reset_n asserted low during the 2nd write of a len=4 copy. Required: mem_we_o=0 immediately; only the first destination word is modified; busy_o=0; a new copy then runs correctly.
- start_i pulsed during WRITE. Required: the pulse is ignored; exactly one done_o pulse results.

Source files
------------

// File: rtl/ucsbece154a_memcpy_if.sv
// Shared memory-port bundle between the memcpy initiator and the memory/mux side.
interface ucsbece154a_memcpy_if;
  logic        mem_req_o;
  logic [31:0] mem_a_o;
  logic        mem_we_o;
  logic [31:0] mem_wd_o;
  logic [31:0] mem_rd_i;

  modport master (
    output mem_req_o, mem_a_o, mem_we_o, mem_wd_o,
    input  mem_rd_i
  );

  modport slave (
    input  mem_req_o, mem_a_o, mem_we_o, mem_wd_o,
    output mem_rd_i
  );
endinterface

// File: rtl/ucsbece154a_memcpy.sv
// DMA-style word copier: validates a request, then moves words in bursts of up to BURST
// (read burst into a local buffer, write it back out) over the shared memory port.
module ucsbece154a_memcpy #(
  parameter int unsigned TEXT_SIZE = 64,
  parameter int unsigned DATA_SIZE = 64,
  parameter int unsigned BURST     = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start_i,
  input  logic [31:0] src_i,
  input  logic [31:0] dst_i,
  input  logic [15:0] len_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  ucsbece154a_memcpy_if.master mem
);

  localparam logic [33:0] TEXT_START = 34'h000400000;
  localparam logic [33:0] DATA_START = 34'h010000000;
  localparam logic [33:0] TEXT_END   = TEXT_START + 34'(4 * TEXT_SIZE);
  localparam logic [33:0] DATA_END   = DATA_START + 34'(4 * DATA_SIZE);

  localparam int unsigned CW = $clog2(BURST + 1);
  localparam int unsigned IW = (BURST > 1) ? $clog2(BURST) : 1;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CHECK = 3'd1;
  localparam logic [2:0] READ  = 3'd2;
  localparam logic [2:0] WRITE = 3'd3;
  localparam logic [2:0] FIN   = 3'd4;

  logic [2:0]    state_q;
  logic [31:0]   src_q, dst_q;
  logic [15:0]   rem_q;
  logic [CW-1:0] idx_q, n_q;
  logic [31:0]   burst_q [BURST];

  logic [33:0] src_lo, src_hi, dst_lo, dst_hi;
  logic        src_text, src_data, dst_data, overlap, aligned, valid, last;
  logic [15:0] rem_dec;

  function automatic logic [CW-1:0] burst_of(input logic [15:0] r);
    return (r >= 16'(BURST)) ? CW'(BURST) : CW'(r);
  endfunction

  // 34-bit range math so src/dst + 4*len can never wrap.
  always_comb begin
    src_lo   = {2'b00, src_q};
    dst_lo   = {2'b00, dst_q};
    src_hi   = src_lo + {16'b0, rem_q, 2'b00};
    dst_hi   = dst_lo + {16'b0, rem_q, 2'b00};
    src_text = (src_lo >= TEXT_START) && (src_hi <= TEXT_END);
    src_data = (src_lo >= DATA_START) && (src_hi <= DATA_END);
    dst_data = (dst_lo >= DATA_START) && (dst_hi <= DATA_END);
    overlap  = (src_lo < dst_hi) && (dst_lo < src_hi);
    aligned  = (src_q[1:0] == 2'b00) && (dst_q[1:0] == 2'b00);
    valid    = aligned && (src_text || src_data) && dst_data && !(src_data && overlap);
    last     = (idx_q == n_q - CW'(1));
    rem_dec  = rem_q - 16'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      idx_q   <= '0;
      n_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            src_q   <= src_i;
            dst_q   <= dst_i;
            rem_q   <= len_i;
            state_q <= CHECK;
          end
        end
        CHECK: begin
          idx_q <= '0;
          if (rem_q == 16'd0) begin
            state_q <= FIN;
          end else if (!valid) begin
            state_q <= IDLE;
          end else begin
            n_q     <= burst_of(rem_q);
            state_q <= READ;
          end
        end
        READ: begin
          src_q <= src_q + 32'd4;
          if (last) begin
            idx_q   <= '0;
            state_q <= WRITE;
          end else begin
            idx_q <= idx_q + CW'(1);
          end
        end
        WRITE: begin
          dst_q <= dst_q + 32'd4;
          rem_q <= rem_dec;
          if (last) begin
            idx_q <= '0;
            if (rem_dec == 16'd0) begin
              state_q <= FIN;
            end else begin
              n_q     <= burst_of(rem_dec);
              state_q <= READ;
            end
          end else begin
            idx_q <= idx_q + CW'(1);
          end
        end
        FIN:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Buffer contents are don't-care after reset, so no reset term.
  always_ff @(posedge clk) begin
    if (state_q == READ) begin
      burst_q[idx_q[IW-1:0]] <= mem.mem_rd_i;
    end
  end

  always_comb begin
    busy_o        = 1'b0;
    done_o        = 1'b0;
    err_o         = 1'b0;
    mem.mem_a_o   = '0;
    mem.mem_we_o  = 1'b0;
    mem.mem_wd_o  = '0;
    case (state_q)
      CHECK: err_o = (rem_q != 16'd0) && !valid;
      READ: begin
        busy_o      = 1'b1;
        mem.mem_a_o = src_q;
      end
      WRITE: begin
        busy_o       = 1'b1;
        mem.mem_a_o  = dst_q;
        mem.mem_we_o = 1'b1;
        mem.mem_wd_o = burst_q[idx_q[IW-1:0]];
      end
      FIN:     done_o = 1'b1;
      default: ;
    endcase
    mem.mem_req_o = busy_o;
  end

endmodule
